sev_seg_scan_ctrl: RTL and testbench
====================================

Name: sev_seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the board's 8-digit seven-segment display. It shares the single segment bus and the existing sev_seg_decoder among NUM_DIGITS digits. Each digit gets a fixed-length slot with a dead-time blank to prevent ghosting. Writers load a shadow digit buffer, and a commit request publishes the whole buffer atomically at the next frame boundary, so the display never tears. Divider result logic (quotient/remainder) sits upstream; the decoder and pad drivers sit downstream.

Parameters:
NUM_DIGITS, 8, number of scanned digits (2..8); digit 0 is rightmost.
PRESCALE, 50000, clk cycles per digit slot.
BLANK_CYCLES, 1000, leading cycles of each slot with all digits off; legal range 1..PRESCALE-1.

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-high.
wr_en  input  1  write one shadow-buffer entry this cycle.
wr_addr  input  3  digit index to write.
wr_data  input  4  hex nibble for that digit.
wr_blank  input  1  1 = digit is dark when active.
commit  input  1  one-cycle request to publish the shadow buffer to the active buffer.
digit_en_n  output  NUM_DIGITS  active-low digit enables, registered.
nibble  output  4  nibble for the decoder, registered.
commit_pending  output  1  high from commit until the copy completes.
frame_done  output  1  one-cycle pulse on the frame-boundary cycle.

Behaviour:
- Reset is asynchronous and takes effect immediately, including mid-frame:
  - shadow and active entries = {nibble 0, blank 1};
  - slot_cnt=0, idx=0, state=BLANK;
  - digit_en_n all 1s, nibble=0, commit_pending=0, frame_done=0.
- Counters:
  - slot_cnt runs 0..PRESCALE-1 and then wraps to 0.
  - On wrap, idx increments; idx wraps from NUM_DIGITS-1 to 0.
  - Frame = NUM_DIGITS*PRESCALE cycles.
- Slot FSM has two states:
  - BLANK: slot_cnt < BLANK_CYCLES.
  - ON: slot_cnt >= BLANK_CYCLES.
- Outputs are registered and aligned to the current slot_cnt/idx:
  - BLANK: digit_en_n all 1s, nibble = active[idx].nibble. The nibble is therefore stable before the enable asserts.
  - ON: digit_en_n has bit idx = 0 and all other bits 1, unless active[idx].blank = 1, in which case all 1s. nibble is unchanged.
- Only one enable bit is ever low at a time. BLANK always separates consecutive lit digits.
- Shadow writes:
  - wr_en with wr_addr < NUM_DIGITS sets shadow[wr_addr] = {wr_data, wr_blank} on the next edge.
  - wr_addr >= NUM_DIGITS: the write is ignored and no state changes.
  - Shadow writes never affect the display without a commit.
- Commit:
  - commit sets commit_pending.
  - Frame-boundary cycle = the cycle with idx=0 and slot_cnt=0 that follows a frame.
  - On the frame-boundary cycle, if commit_pending is set: active <= shadow (whole buffer, one edge), commit_pending cleared.
  - frame_done pulses on every frame boundary, whether or not a copy occurs.
  - Multiple commits before a boundary collapse into one.
- Simultaneous events:
  - Commit in the boundary cycle itself: it is not taken by that boundary. It sets pending and applies at the following boundary.
  - Write in the copy cycle: the copy uses the pre-write shadow. The write lands in shadow and needs another commit.
  - Write and commit in the same cycle: both are honoured. The write is included in the next boundary copy.
- The first boundary after reset release occurs one full frame later. Until then the display is dark, because reset leaves every entry blanked.

Decomposition:
- Package sev_seg_pkg:
  - slot-state enum {SLOT_BLANK, SLOT_ON};
  - digit-entry struct {nibble[3:0], blank};
  - DIGIT_ADDR_W=3.
- Sub-module sev_seg_digit_buffer holds the shadow and active arrays, the write port, the copy strobe and the read mux by idx.
- sev_seg_scan_ctrl keeps the counters, FSM, commit logic and output registers.

Test Plan:
Bench parameters: NUM_DIGITS=4, PRESCALE=4, BLANK_CYCLES=1 (frame = 16 cycles) unless noted.
1. Hold reset, then release → digit_en_n=4'b1111, nibble=0, commit_pending=0. The display stays 1111 for a full 16 cycles. frame_done pulses at cycle 16.
2. Write digits 0..3 = 1,2,3,4 (blank=0), then commit → commit_pending=1 until the next boundary, then drops together with the frame_done pulse. Each slot then shows 1111 for 1 cycle, then bit i low for 3 cycles, with nibble=i+1. The sequence repeats every 16 cycles.
3. Rewrite digit 1 = 9 with no commit → the display is unchanged (digit 1 still shows 2) for 3 full frames. Commit → 9 appears starting at the next boundary only.
4. Write digit 2 with blank=1, then commit → digit_en_n stays 1111 for all 4 cycles of slot 2 in every subsequent frame. Other digits are unaffected.
5. Assert commit exactly on the boundary cycle, and write digit 0 = A in the copy cycle of a prior commit → the first case applies one frame later; the A does not appear until a further commit plus boundary.
6. Assert reset during slot 2 ON → digit_en_n=1111 and nibble=0 immediately (asynchronous), pending cleared. After release the display is dark for one frame.
7. With NUM_DIGITS=6, write wr_addr=6 and 7 with wr_data=F, then commit → no visible change on any digit.

Source files
------------

// File: rtl/sev_seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
//   slot_state_t  : per-slot phase (dark lead-in, then lit).
//   digit_entry_t : one display-buffer entry (hex nibble + dark flag).
//   ENTRY_RESET   : value every buffer entry takes on reset (nibble 0, dark).
package sev_seg_pkg;

    localparam int DIGIT_ADDR_W = 3;

    typedef enum logic {
        SLOT_BLANK = 1'b0,
        SLOT_ON    = 1'b1
    } slot_state_t;

    typedef struct packed {
        logic [3:0] nibble;
        logic       blank;
    } digit_entry_t;

    localparam digit_entry_t ENTRY_RESET = '{nibble: 4'h0, blank: 1'b1};

endpackage

// File: rtl/sev_seg_scan_ctrl_if.sv
// Host-side write/commit bus of the scan controller.
//   wr_en/wr_addr/wr_data/wr_blank : one shadow-buffer write per cycle.
//   commit                         : request to publish the shadow buffer.
//   commit_pending                 : status, high until the publish happens.
// master = writer (host logic), slave = scan controller.
interface sev_seg_scan_ctrl_if;
    import sev_seg_pkg::*;

    logic                    wr_en;
    logic [DIGIT_ADDR_W-1:0] wr_addr;
    logic [3:0]              wr_data;
    logic                    wr_blank;
    logic                    commit;
    logic                    commit_pending;

    modport master (
        output wr_en, wr_addr, wr_data, wr_blank, commit,
        input  commit_pending
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_blank, commit,
        output commit_pending
    );

endinterface

// File: rtl/sev_seg_digit_buffer.sv
// Double-buffered digit store: a shadow array that writers update and an
// active array the scanner displays. A single copy strobe moves the whole
// shadow array into the active array on one edge.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset.
//   wr_en, wr_addr,
//   wr_data, wr_blank : shadow write port (addresses >= NUM_DIGITS ignored).
//   copy              : publish shadow -> active on this edge.
//   rd_idx, rd_entry  : read of the active entry as it will be after this
//                       edge (copy forwarded), so registered outputs computed
//                       from it line up with the freshly published buffer.
module sev_seg_digit_buffer
    import sev_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [DIGIT_ADDR_W-1:0] wr_addr,
    input  logic [3:0]              wr_data,
    input  logic                    wr_blank,
    input  logic                    copy,
    input  logic [DIGIT_ADDR_W-1:0] rd_idx,
    output digit_entry_t            rd_entry
);

    digit_entry_t fwd_entry [NUM_DIGITS];

    // One register pair per digit. An address with no matching entry simply
    // hits nothing, which is how out-of-range writes are dropped.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_entry
            digit_entry_t shadow_reg;
            digit_entry_t active_reg;
            logic         wr_hit;

            assign wr_hit = wr_en && (wr_addr == DIGIT_ADDR_W'(gi));

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    shadow_reg <= ENTRY_RESET;
                    active_reg <= ENTRY_RESET;
                end else begin
                    if (wr_hit) begin
                        shadow_reg <= '{nibble: wr_data, blank: wr_blank};
                    end
                    // Copy samples the pre-edge shadow, so a write on the
                    // copy edge stays in shadow for a later commit.
                    if (copy) begin
                        active_reg <= shadow_reg;
                    end
                end
            end

            assign fwd_entry[gi] = copy ? shadow_reg : active_reg;
        end
    endgenerate

    always_comb begin
        rd_entry = ENTRY_RESET;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (rd_idx == DIGIT_ADDR_W'(i)) begin
                rd_entry = fwd_entry[i];
            end
        end
    end

endmodule

// File: rtl/sev_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a NUM_DIGITS seven-segment display.
// Each digit owns a PRESCALE-cycle slot; the first BLANK_CYCLES of every
// slot keep all digits dark to avoid ghosting. Commits publish the shadow
// buffer atomically at the next frame boundary.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset.
//   host        : write/commit bus (slave side), drives commit_pending.
//   digit_en_n  : active-low digit enables, registered.
//   nibble      : nibble for the downstream decoder, registered.
//   frame_done  : one-cycle pulse on each frame-boundary cycle.
// All output registers are loaded from the next counter values, so they
// describe the same slot position the counters hold in that cycle.
module sev_seg_scan_ctrl
    import sev_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    sev_seg_scan_ctrl_if.slave    host,
    output logic [NUM_DIGITS-1:0] digit_en_n,
    output logic [3:0]            nibble,
    output logic                  frame_done
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0]        CNT_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0]        BLANK_LIM = CNT_W'(BLANK_CYCLES);
    localparam logic [DIGIT_ADDR_W-1:0] IDX_LAST  = DIGIT_ADDR_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        slot_cnt_reg, slot_cnt_next;
    logic [DIGIT_ADDR_W-1:0] idx_reg, idx_next;
    slot_state_t             state_reg, state_next;
    logic [NUM_DIGITS-1:0]   digit_en_n_reg, digit_en_n_next;
    logic [3:0]              nibble_reg, nibble_next;
    logic                    pending_reg;
    logic                    frame_done_reg;

    logic         slot_wrap;
    logic         frame_wrap;
    logic         copy;
    digit_entry_t entry;

    assign slot_wrap  = (slot_cnt_reg == CNT_LAST);
    assign frame_wrap = slot_wrap && (idx_reg == IDX_LAST);
    // The copy lands on the edge that enters the boundary cycle, so the
    // boundary cycle already shows the new buffer (still dark in BLANK).
    assign copy       = frame_wrap && pending_reg;

    sev_seg_digit_buffer #(
        .NUM_DIGITS(NUM_DIGITS)
    ) u_digit_buffer (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (host.wr_en),
        .wr_addr  (host.wr_addr),
        .wr_data  (host.wr_data),
        .wr_blank (host.wr_blank),
        .copy     (copy),
        .rd_idx   (idx_next),
        .rd_entry (entry)
    );

    always_comb begin
        slot_cnt_next = slot_wrap ? '0 : slot_cnt_reg + 1'b1;
        idx_next      = idx_reg;
        if (slot_wrap) begin
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
        end

        state_next = state_reg;
        case (state_reg)
            SLOT_BLANK: if (slot_cnt_next >= BLANK_LIM) state_next = SLOT_ON;
            SLOT_ON:    if (slot_wrap)                  state_next = SLOT_BLANK;
            default:    state_next = SLOT_BLANK;
        endcase

        // Nibble is loaded during BLANK and frozen while the digit is lit.
        nibble_next = (state_next == SLOT_BLANK) ? entry.nibble : nibble_reg;
    end

    // At most one enable can be low: only bit idx_next can match.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_en
            assign digit_en_n_next[gi] = ~((state_next == SLOT_ON) && !entry.blank &&
                                           (idx_next == DIGIT_ADDR_W'(gi)));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt_reg   <= '0;
            idx_reg        <= '0;
            state_reg      <= SLOT_BLANK;
            digit_en_n_reg <= '1;
            nibble_reg     <= 4'h0;
            pending_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            slot_cnt_reg   <= slot_cnt_next;
            idx_reg        <= idx_next;
            state_reg      <= state_next;
            digit_en_n_reg <= digit_en_n_next;
            nibble_reg     <= nibble_next;
            frame_done_reg <= frame_wrap;
            // A commit arriving on the copy edge is not part of this copy;
            // it re-arms pending for the following boundary.
            if (host.commit) begin
                pending_reg <= 1'b1;
            end else if (copy) begin
                pending_reg <= 1'b0;
            end
        end
    end

    assign digit_en_n          = digit_en_n_reg;
    assign nibble              = nibble_reg;
    assign frame_done          = frame_done_reg;
    assign host.commit_pending = pending_reg;

endmodule

// File: tb/tb_sev_seg_scan_ctrl.sv
// Testbench for sev_seg_scan_ctrl: a 4-digit and a 6-digit instance share one
// write/commit stimulus stream and are checked every cycle against a
// time-based behavioural model, plus literal spot checks.
module tb_sev_seg_scan_ctrl;
    import sev_seg_pkg::*;

    localparam int P  = 4;
    localparam int BL = 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       wr_en_s    = 1'b0;
    logic [2:0] wr_addr_s  = 3'd0;
    logic [3:0] wr_data_s  = 4'h0;
    logic       wr_blank_s = 1'b0;
    logic       commit_s   = 1'b0;

    sev_seg_scan_ctrl_if bus4 ();
    sev_seg_scan_ctrl_if bus6 ();

    assign bus4.wr_en = wr_en_s;   assign bus6.wr_en = wr_en_s;
    assign bus4.wr_addr = wr_addr_s; assign bus6.wr_addr = wr_addr_s;
    assign bus4.wr_data = wr_data_s; assign bus6.wr_data = wr_data_s;
    assign bus4.wr_blank = wr_blank_s; assign bus6.wr_blank = wr_blank_s;
    assign bus4.commit = commit_s; assign bus6.commit = commit_s;

    logic [3:0] en4, nib4, nib6;
    logic [5:0] en6;
    logic       fd4, fd6;

    sev_seg_scan_ctrl #(.NUM_DIGITS(4), .PRESCALE(P), .BLANK_CYCLES(BL)) dut4 (
        .clk(clk), .reset(reset), .host(bus4),
        .digit_en_n(en4), .nibble(nib4), .frame_done(fd4));

    sev_seg_scan_ctrl #(.NUM_DIGITS(6), .PRESCALE(P), .BLANK_CYCLES(BL)) dut6 (
        .clk(clk), .reset(reset), .host(bus6),
        .digit_en_n(en6), .nibble(nib6), .frame_done(fd6));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", name, act, exp, t_m, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         t_m = 0;          // cycles since reset release (0 = reset-state cycle)
    bit         model_valid = 0;
    logic [3:0] sh_nib [2][8];
    logic [3:0] ac_nib [2][8];
    bit         sh_blk [2][8];
    bit         ac_blk [2][8];
    bit         pend   [2];

    function automatic int nd_of(input int k);
        return (k == 0) ? 4 : 6;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            pend[k] = 0;
            for (int d = 0; d < 8; d++) begin
                sh_nib[k][d] = 4'h0; ac_nib[k][d] = 4'h0;
                sh_blk[k][d] = 1;    ac_blk[k][d] = 1;
            end
        end
        t_m = 0;
        model_valid = 1;
    endtask

    task automatic compare_all();
        int f, pos, idx, s, exp_en, exp_nib, exp_fd, act_en, act_nib, act_fd, act_pd;
        for (int k = 0; k < 2; k++) begin
            f   = nd_of(k) * P;
            pos = t_m % f;
            idx = pos / P;
            s   = pos % P;
            exp_fd  = (t_m > 0 && pos == 0) ? 1 : 0;
            exp_nib = int'(ac_nib[k][idx]);
            exp_en  = (1 << nd_of(k)) - 1;
            if (s >= BL && !ac_blk[k][idx]) exp_en = exp_en & ~(1 << idx);
            act_en  = (k == 0) ? int'(en4) : int'(en6);
            act_nib = (k == 0) ? int'(nib4) : int'(nib6);
            act_fd  = (k == 0) ? int'(fd4) : int'(fd6);
            act_pd  = (k == 0) ? int'(bus4.commit_pending) : int'(bus6.commit_pending);
            chk((k == 0) ? "model_en4" : "model_en6", act_en, exp_en);
            chk((k == 0) ? "model_nib4" : "model_nib6", act_nib, exp_nib);
            chk((k == 0) ? "model_fd4" : "model_fd6", act_fd, exp_fd);
            chk((k == 0) ? "model_pend4" : "model_pend6", act_pd, int'(pend[k]));
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                model_reset();
            end else if (model_valid) begin
                for (int k = 0; k < 2; k++) begin
                    if ((t_m + 1) % (nd_of(k) * P) == 0) begin
                        if (pend[k]) begin
                            for (int d = 0; d < 8; d++) begin
                                ac_nib[k][d] = sh_nib[k][d];
                                ac_blk[k][d] = sh_blk[k][d];
                            end
                            pend[k] = 0;
                        end
                    end
                    if (commit_s) pend[k] = 1;
                    if (wr_en_s && int'(wr_addr_s) < nd_of(k)) begin
                        sh_nib[k][wr_addr_s] = wr_data_s;
                        sh_blk[k][wr_addr_s] = wr_blank_s;
                    end
                end
                t_m++;
                #1;
                if (!reset) compare_all();
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_write(input int addr, input int data, input bit blk);
        wr_en_s = 1'b1; wr_addr_s = 3'(addr); wr_data_s = 4'(data); wr_blank_s = blk;
        @(negedge clk);
        wr_en_s = 1'b0;
    endtask

    task automatic do_commit();
        commit_s = 1'b1;
        @(negedge clk);
        commit_s = 1'b0;
    endtask

    // Advance at least one cycle, then until t_m % m == pos (bounded).
    task automatic goto_pos(input int m, input int pos);
        int n;
        n = 0;
        @(negedge clk);
        while ((t_m % m) != pos && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("goto_bound", (t_m % m), pos);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_en4", int'(en4), 'hF);
        chk("rst_nib4", int'(nib4), 0);
        chk("rst_pend4", int'(bus4.commit_pending), 0);
        chk("rst_fd4", int'(fd4), 0);
        @(negedge clk);
        reset = 1'b0;

        // 1: dark first frame, first boundary at cycle 16
        goto_pos(16, 0);
        chk("t1_fd_at16", int'(fd4), 1);
        chk("t1_en_at16", int'(en4), 'hF);

        // 2: load 1,2,3,4 and commit
        do_write(0, 1, 0); do_write(1, 2, 0); do_write(2, 3, 0); do_write(3, 4, 0);
        do_commit();
        chk("t2_pend_set", int'(bus4.commit_pending), 1);
        goto_pos(16, 0);
        chk("t2_pend_clr", int'(bus4.commit_pending), 0);
        chk("t2_fd", int'(fd4), 1);
        goto_pos(16, 1);
        chk("t2_en_d0", int'(en4), 'hE);
        chk("t2_nib_d0", int'(nib4), 1);
        goto_pos(16, 9);
        chk("t2_en_d2", int'(en4), 'hB);
        chk("t2_nib_d2", int'(nib4), 3);

        // 3: uncommitted write stays invisible
        do_write(1, 9, 0);
        for (int f = 0; f < 3; f++) begin
            goto_pos(16, 5);
            chk("t3_nib_old", int'(nib4), 2);
        end
        do_commit();
        goto_pos(16, 5);
        chk("t3_nib_new", int'(nib4), 9);
        chk("t3_en_d1", int'(en4), 'hD);

        // 4: blanked digit 2
        do_write(2, 7, 1);
        do_commit();
        goto_pos(16, 0);
        goto_pos(16, 9);
        chk("t4_en_d2_dark", int'(en4), 'hF);
        goto_pos(16, 13);
        chk("t4_en_d3", int'(en4), 'h7);
        chk("t4_nib_d3", int'(nib4), 4);

        // 5a: commit in the boundary cycle applies one frame later
        do_write(3, 5, 0);
        goto_pos(16, 0);
        do_commit();
        chk("t5_pend", int'(bus4.commit_pending), 1);
        goto_pos(16, 13);
        chk("t5_nib_not_yet", int'(nib4), 4);
        goto_pos(16, 13);
        chk("t5_nib_applied", int'(nib4), 5);

        // 5b: write in the copy cycle is not included
        do_commit();
        goto_pos(16, 0);
        do_write(0, 'hA, 0);
        chk("t5_en_d0", int'(en4), 'hE);
        chk("t5_nib_d0_old", int'(nib4), 1);
        goto_pos(16, 1);
        chk("t5_nib_d0_still", int'(nib4), 1);
        do_commit();
        goto_pos(16, 1);
        chk("t5_nib_d0_A", int'(nib4), 'hA);

        // 6: asynchronous reset mid-slot
        do_commit();
        goto_pos(16, 9);
        #2 reset = 1'b1;
        #1;
        chk("t6_en4", int'(en4), 'hF);
        chk("t6_nib4", int'(nib4), 0);
        chk("t6_pend4", int'(bus4.commit_pending), 0);
        chk("t6_fd4", int'(fd4), 0);
        chk("t6_en6", int'(en6), 'h3F);
        chk("t6_pend6", int'(bus6.commit_pending), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        goto_pos(16, 1);
        chk("t6_dark_after", int'(en4), 'hF);

        // 7: out-of-range addresses on the 6-digit instance
        for (int d = 0; d < 6; d++) do_write(d, d + 1, 0);
        do_commit();
        goto_pos(24, 0);
        goto_pos(24, 1);
        chk("t7_en6_d0", int'(en6), 'h3E);
        chk("t7_nib6_d0", int'(nib6), 1);
        do_write(6, 'hF, 0);
        do_write(7, 'hF, 0);
        do_commit();
        goto_pos(24, 0);
        goto_pos(24, 21);
        chk("t7_en6_d5", int'(en6), 'h1F);
        chk("t7_nib6_d5", int'(nib6), 6);

        // randomized phase, checked by the model every cycle
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            wr_en_s    = 1'($urandom_range(0, 1));
            wr_addr_s  = 3'($urandom_range(0, 7));
            wr_data_s  = 4'($urandom_range(0, 15));
            wr_blank_s = ($urandom_range(0, 3) == 0);
            commit_s   = ($urandom_range(0, 15) == 0);
        end
        @(negedge clk);
        wr_en_s = 1'b0;
        commit_s = 1'b0;
        repeat (60) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
